// File: rtl/wb_pipelined_memory_pkg.sv
// Shared types and the request classifier for the pipelined Wishbone slave RAM.
// The width-specific response record is built from the same fields inside the modules.
package wb_pipelined_memory_pkg;

    typedef enum logic [1:0] {
        ACK_NORMAL = 2'd0,
        ACK_OOR    = 2'd1,
        ERR        = 2'd2
    } req_class_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    // The forced error wins over the range check, which wins over a normal access.
    function automatic req_class_e classify_req(
        input logic force_err,
        input logic out_of_range,
        input logic err_on_oor
    );
        req_class_e cls;
        if (force_err) begin
            cls = ERR;
        end else if (out_of_range) begin
            cls = err_on_oor ? ERR : ACK_OOR;
        end else begin
            cls = ACK_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/wb_mem_resp_pipe.sv
// Fixed-latency response delay line: {valid, err, data} shifted one stage per clock.
// The last stage drives the bus outputs; a valid last stage retires on the next edge.
module wb_mem_resp_pipe #(
    parameter int DW      = 32,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_err,
    output logic [DW-1:0] out_data,
    output logic          retire
);

    logic [LATENCY-1:0] valid_r;
    logic [LATENCY-1:0] err_r;
    logic [DW-1:0]      data_r [LATENCY];

    // Delay line; a flush drops every in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            err_r   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
            err_r   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            err_r[0]   <= in_err;
            data_r[0]  <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                err_r[i]   <= err_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_err   = err_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];
    assign retire    = valid_r[LATENCY-1];

endmodule

// File: rtl/wb_pipelined_memory.sv
// Wishbone B4 pipelined slave RAM with byte selects, fixed response latency,
// bounded outstanding requests, cycle-abort flush and a selectable out-of-range policy.
module wb_pipelined_memory
    import wb_pipelined_memory_pkg::*;
#(
    parameter int DW              = 32,
    parameter int AW              = 32,
    parameter int DEPTH           = 128,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 1,
    parameter int ERR_ON_OOR      = 0
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_wb_cyc,
    input  logic                               i_wb_stb,
    input  logic                               i_wb_we,
    input  logic [AW-1:0]                      i_wb_addr,
    input  logic [DW-1:0]                      i_wb_data,
    input  logic [DW/8-1:0]                    i_wb_sel,
    output logic                               o_wb_ack,
    output logic                               o_wb_err,
    output logic                               o_wb_stall,
    output logic [DW-1:0]                      o_wb_data,
    input  logic                               i_force_stall,
    input  logic                               i_force_error,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding
);

    localparam int SW = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [DW-1:0] mem_r [DEPTH];
    logic [CW-1:0] outstanding_r;

    logic          oor_s;
    logic          accept_s;
    logic          retire_s;
    logic          mem_we_s;
    logic          resp_valid_s;
    logic          resp_err_s;
    logic [DW-1:0] resp_data_s;
    logic [DW-1:0] rd_data_s;
    logic [IW-1:0] idx_s;
    logic          pipe_valid_s;
    logic          pipe_err_s;
    logic [DW-1:0] pipe_data_s;
    req_class_e    cls_s;

    assign oor_s     = (i_wb_addr >= AW'(DEPTH));
    assign idx_s     = i_wb_addr[IW-1:0];
    assign rd_data_s = mem_r[idx_s];
    assign cls_s     = classify_req(i_force_error, oor_s, ERR_ON_OOR != 0);

    // A retiring response frees its slot in the same cycle, so a full pipe still accepts then.
    assign o_wb_stall = i_force_stall |
                        ((outstanding_r == CW'(MAX_OUTSTANDING)) & ~retire_s);
    assign accept_s   = i_wb_cyc & i_wb_stb & ~o_wb_stall;

    // Build the response entered into the delay line and the RAM write strobe.
    always_comb begin
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        resp_data_s  = '0;
        mem_we_s     = 1'b0;
        if (accept_s) begin
            resp_valid_s = 1'b1;
            case (cls_s)
                ACK_NORMAL: begin
                    if (i_wb_we) begin
                        mem_we_s = 1'b1;
                    end else begin
                        resp_data_s = rd_data_s;
                    end
                end
                ACK_OOR: begin
                    resp_err_s = 1'b0;
                end
                ERR: begin
                    resp_err_s = 1'b1;
                end
                default: begin
                    resp_err_s = 1'b1;
                end
            endcase
        end else begin
            resp_valid_s = 1'b0;
        end
    end

    // Byte-masked RAM write; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < SW; b++) begin
                if (i_wb_sel[b]) begin
                    mem_r[idx_s][b*8 +: 8] <= i_wb_data[b*8 +: 8];
                end
            end
        end
    end

    // In-flight request counter; dropping cyc discards everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_r <= '0;
        end else if (!i_wb_cyc) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, retire_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    wb_mem_resp_pipe #(
        .DW      (DW),
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (~i_wb_cyc),
        .in_valid  (resp_valid_s),
        .in_err    (resp_err_s),
        .in_data   (resp_data_s),
        .out_valid (pipe_valid_s),
        .out_err   (pipe_err_s),
        .out_data  (pipe_data_s),
        .retire    (retire_s)
    );

    assign o_wb_ack      = pipe_valid_s & ~pipe_err_s;
    assign o_wb_err      = pipe_valid_s & pipe_err_s;
    assign o_wb_data     = pipe_data_s;
    assign o_outstanding = outstanding_r;

endmodule

// File: doc/wb_pipelined_memory.md
Name: wb_pipelined_memory

Overview:
- Parametrised Wishbone B4 pipelined slave RAM: the next-generation bus target for exercising wbdbgbus and other masters.
- Generalises the single-cycle debug-harness memory with:
  - configurable data/address width;
  - byte selects;
  - fixed multi-cycle response latency;
  - bounded outstanding requests with internal backpressure;
  - cycle-abort flush;
  - selectable out-of-range policy.
- Sits directly on a master's Wishbone port, in simulation and on FPGA.

Parameters:
DW, 32, data width; multiple of 8.
AW, 32, word-address width.
DEPTH, 128, memory words; addresses 0..DEPTH-1 are backed.
LATENCY, 1, cycles from acceptance edge to ack/err; >=1.
MAX_OUTSTANDING, 1, accepted-but-unanswered limit; 1..LATENCY.
ERR_ON_OOR, 0, 1 = out-of-range access returns err; 0 = ack with data 0, write dropped.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
i_wb_we  in  1  write enable
i_wb_addr  in  AW  word address
i_wb_data  in  DW  write data
i_wb_sel  in  DW/8  byte selects
o_wb_ack  out  1  ack
o_wb_err  out  1  error
o_wb_stall  out  1  stall
o_wb_data  out  DW  read data
i_force_stall  in  1  test hook: stall all requests
i_force_error  in  1  test hook: err for requests accepted while high
o_outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight count

Behaviour:
- Reset, async on i_rst_n low:
  - o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_outstanding=0.
  - Response pipeline cleared.
  - RAM contents not reset.
- Stall is combinational: o_wb_stall = i_force_stall | (o_outstanding==MAX_OUTSTANDING && no response retiring this cycle).
- Accept when i_wb_cyc & i_wb_stb & ~o_wb_stall at a rising edge. One request per cycle maximum.
- Request classification at accept, in priority order:
  - i_force_error=1 -> err; no RAM write.
  - addr>=DEPTH -> err if ERR_ON_OOR, else ack; write dropped, read data 0.
  - else normal access.
- Normal write:
  - Bytes with sel=1 are written at the accept edge; other bytes unchanged.
  - sel=0 is legal: ack with no change.
- Normal read: full word captured at the accept edge. Sel is ignored for reads; the full word is returned.
- Timing and ordering:
  - The response appears exactly LATENCY cycles after the accept edge. With LATENCY=1, ack is high in the cycle after the accept.
  - Responses are strictly in order.
  - Exactly one of ack/err is high per accepted request; ack and err are never high together.
- o_wb_data equals read data during a read ack, and 0 in every other cycle (write acks, err, idle).
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- o_outstanding:
  - +1 on accept, -1 on response; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- Abort: i_wb_cyc low at any edge flushes all in-flight responses.
  - No ack/err is emitted for them; o_outstanding becomes 0 the next cycle.
  - Writes already accepted remain committed.
  - Requests are not accepted while cyc is low.
- i_wb_stb without i_wb_cyc is ignored.
- Reset mid-transaction behaves like abort plus output clear.
- Latency pipeline: LATENCY-stage shift register of {valid, err, data}, all stages cleared on flush or reset.

Decomposition:
- Package wb_pipelined_memory_pkg holds:
  - resp_t struct {logic valid; logic err; logic [DW-1:0] data} (parametrised via typedef in the instantiating module, or a fixed 32-bit default);
  - a function classifying the request into ACK_NORMAL / ACK_OOR / ERR.
- One sub-module, wb_mem_resp_pipe:
  - LATENCY-deep valid/err/data delay line with synchronous flush and async reset;
  - outputs a retire flag used for the stall calculation.

Test Plan:
- LATENCY=1, MAX_OUTSTANDING=1: write 0xDEADBEEF to addr 5, then read addr 5 -> ack one cycle after each accept; read data 0xDEADBEEF; data 0 on the write ack.
- Byte select: addr 3 holds 0x11223344; write 0xAABBCCDD with sel=4'b0101 -> read returns 0x11BB33DD.
- LATENCY=3, MAX_OUTSTANDING=2: stb held high with 4 back-to-back reads.
  - Stall asserts after 2 accepts and drops on the first retire.
  - Acks arrive in order, 3 cycles after each accept.
  - o_outstanding never exceeds 2.
- Out-of-range access to addr 200 (DEPTH=128):
  - ERR_ON_OOR=0 -> read acks with data 0; the write does not alias addr 72.
  - ERR_ON_OOR=1 -> err, no ack.
- i_force_error high on one accept of a write to addr 7 -> err; a subsequent read of addr 7 returns the old value.
- i_force_stall and abort: with i_force_stall=1, nothing is accepted for 10 cycles.
  - Then, with LATENCY=4, accept 2 reads and drop cyc 1 cycle later -> no ack/err ever appears; o_outstanding=0.
  - Pulsing i_rst_n low mid-burst clears all outputs immediately.
